// File: rtl/struct_array_reader.sv
// Captures a packed {a[NELEM], b} struct image and an index range, then streams
// the selected elements of a one per beat, with field b attached to the last beat.
module struct_array_reader #(
    parameter int NELEM     = 8,
    parameter int EW        = 8,
    parameter int BW        = 16,
    parameter int ASCENDING = 0,
    parameter int IW        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NELEM*EW+BW-1:0]  in_data,
    input  logic [IW-1:0]           rd_lo,
    input  logic [IW-1:0]           rd_hi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EW-1:0]           out_elem,
    output logic [IW-1:0]           out_idx,
    output logic                    out_oob,
    output logic                    out_last,
    output logic [BW-1:0]           out_tail
);

    localparam int DW = NELEM*EW + BW;
    localparam logic [IW:0] NELEM_W = (IW+1)'(NELEM);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   hi_q, hi_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic            dn_q, dn_d;

    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [EW-1:0]   out_elem_q, out_elem_d;
    logic [IW-1:0]   out_idx_q, out_idx_d;
    logic            out_oob_q, out_oob_d;
    logic            out_last_q, out_last_d;
    logic [BW-1:0]   out_tail_q, out_tail_d;

    // Element idx of field a; placement depends on the declared array ordering.
    function automatic logic [EW-1:0] elem_at(input logic [DW-1:0] img,
                                              input logic [IW-1:0] idx);
        logic [EW-1:0] r;
        r = {EW{1'b0}};
        for (int k = 0; k < NELEM; k++) begin
            if (idx == IW'(k)) begin
                r = img[BW + EW*((ASCENDING != 0) ? (NELEM-1-k) : k) +: EW];
            end
        end
        return r;
    endfunction

    // Next-state logic; output registers are computed from next state so they stay registered.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        hi_d    = hi_q;
        cur_d   = cur_q;
        dn_d    = dn_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    hi_d    = rd_hi;
                    cur_d   = rd_lo;
                    dn_d    = (rd_hi < rd_lo);
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        cur_d = dn_q ? (cur_q - {{(IW-1){1'b0}}, 1'b1})
                                     : (cur_q + {{(IW-1){1'b0}}, 1'b1});
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_elem_d  = {EW{1'b0}};
        out_idx_d   = {IW{1'b0}};
        out_oob_d   = 1'b0;
        out_last_d  = 1'b0;
        out_tail_d  = {BW{1'b0}};
        if (state_d == STREAM) begin
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_idx_d   = cur_d;
            out_oob_d   = ({1'b0, cur_d} >= NELEM_W);
            out_elem_d  = out_oob_d ? {EW{1'b0}} : elem_at(data_d, cur_d);
            out_last_d  = (cur_d == hi_d);
            out_tail_d  = out_last_d ? data_d[BW-1:0] : {BW{1'b0}};
        end else begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end
    end

    // State, captured image and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= {DW{1'b0}};
            hi_q        <= {IW{1'b0}};
            cur_q       <= {IW{1'b0}};
            dn_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_elem_q  <= {EW{1'b0}};
            out_idx_q   <= {IW{1'b0}};
            out_oob_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_tail_q  <= {BW{1'b0}};
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            hi_q        <= hi_d;
            cur_q       <= cur_d;
            dn_q        <= dn_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_elem_q  <= out_elem_d;
            out_idx_q   <= out_idx_d;
            out_oob_q   <= out_oob_d;
            out_last_q  <= out_last_d;
            out_tail_q  <= out_tail_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_elem  = out_elem_q;
    assign out_idx   = out_idx_q;
    assign out_oob   = out_oob_q;
    assign out_last  = out_last_q;
    assign out_tail  = out_tail_q;

endmodule

// File: tb/tb_struct_array_reader.sv
// Directed bench for struct_array_reader: one instance per array ordering,
// driven by the same stimulus, with hand-computed element tables.
module tb_struct_array_reader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [79:0] in_data;
    logic [3:0]  rd_lo;
    logic [3:0]  rd_hi;
    logic        out_ready;

    logic        d_in_ready, d_out_valid, d_out_oob, d_out_last;
    logic [7:0]  d_out_elem;
    logic [3:0]  d_out_idx;
    logic [15:0] d_out_tail;

    logic        a_in_ready, a_out_valid, a_out_oob, a_out_last;
    logic [7:0]  a_out_elem;
    logic [3:0]  a_out_idx;
    logic [15:0] a_out_tail;

    int total = 0;
    int bad   = 0;

    localparam logic [79:0] IMG  = 80'hFC00_4200_0012_3400_FFFC;
    localparam logic [15:0] TAIL = 16'hFFFC;

    logic [7:0] exp_d [8] = '{8'h00, 8'h34, 8'h12, 8'h00, 8'h00, 8'h42, 8'h00, 8'hFC};
    logic [7:0] exp_a [8] = '{8'hFC, 8'h00, 8'h42, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00};

    struct_array_reader #(.NELEM(8), .EW(8), .BW(16), .ASCENDING(0), .IW(4)) u_desc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_data(in_data), .rd_lo(rd_lo), .rd_hi(rd_hi), .out_valid(d_out_valid),
        .out_ready(out_ready), .out_elem(d_out_elem), .out_idx(d_out_idx),
        .out_oob(d_out_oob), .out_last(d_out_last), .out_tail(d_out_tail)
    );

    struct_array_reader #(.NELEM(8), .EW(8), .BW(16), .ASCENDING(1), .IW(4)) u_asc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .rd_lo(rd_lo), .rd_hi(rd_hi), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_elem(a_out_elem), .out_idx(a_out_idx),
        .out_oob(a_out_oob), .out_last(a_out_last), .out_tail(a_out_tail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one image for a single accepting edge.
    task automatic start(input logic [3:0] lo, input logic [3:0] hi);
        in_valid = 1'b1;
        in_data  = IMG;
        rd_lo    = lo;
        rd_hi    = hi;
        tick();
        in_valid = 1'b0;
        in_data  = 80'h0;
        rd_lo    = 4'h0;
        rd_hi    = 4'h0;
    endtask

    // Compare the descending-order instance against one expected beat.
    task automatic chk_beat(input logic [3:0] idx, input logic [7:0] elem,
                            input logic oob, input logic last);
        check("valid", {31'd0, d_out_valid}, 32'd1);
        check("in_ready_busy", {31'd0, d_in_ready}, 32'd0);
        check("idx", {28'd0, d_out_idx}, {28'd0, idx});
        check("elem", {24'd0, d_out_elem}, {24'd0, elem});
        check("oob", {31'd0, d_out_oob}, {31'd0, oob});
        check("last", {31'd0, d_out_last}, {31'd0, last});
        check("tail", {16'd0, d_out_tail}, last ? {16'd0, TAIL} : 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        check(tag, {31'd0, d_out_valid}, 32'd0);
        check(tag, {31'd0, d_in_ready}, 32'd1);
        check(tag, {24'd0, d_out_elem}, 32'd0);
        check(tag, {28'd0, d_out_idx}, 32'd0);
        check(tag, {16'd0, d_out_tail}, 32'd0);
        check(tag, {30'd0, d_out_oob, d_out_last}, 32'd0);
    endtask

    initial begin
        logic [15:0] stall_pat;
        int          k;
        int          cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 80'h0;
        rd_lo     = 4'h0;
        rd_hi     = 4'h0;
        out_ready = 1'b1;
        #12;
        chk_idle("reset");
        check("reset_asc_ready", {31'd0, a_in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Full 0..7 read on both orderings, one beat per cycle.
        start(4'd0, 4'd7);
        for (int i = 0; i < 8; i++) begin
            chk_beat(4'(i), exp_d[i], 1'b0, i == 7);
            check("asc_elem", {24'd0, a_out_elem}, {24'd0, exp_a[i]});
            check("asc_last", {31'd0, a_out_last}, {31'd0, (i == 7)});
            check("asc_tail", {16'd0, a_out_tail}, (i == 7) ? {16'd0, TAIL} : 32'd0);
            tick();
        end
        chk_idle("idle_after_full");
        check("asc_idle", {31'd0, a_out_valid}, 32'd0);

        // Descending index range 2 -> 1.
        start(4'd2, 4'd1);
        chk_beat(4'd2, 8'h12, 1'b0, 1'b0);
        tick();
        chk_beat(4'd1, 8'h34, 1'b0, 1'b1);
        tick();
        chk_idle("idle_after_desc");

        // Range running past the last element.
        start(4'd7, 4'd9);
        chk_beat(4'd7, 8'hFC, 1'b0, 1'b0);
        tick();
        chk_beat(4'd8, 8'h00, 1'b1, 1'b0);
        tick();
        chk_beat(4'd9, 8'h00, 1'b1, 1'b1);
        tick();
        chk_idle("idle_after_oob");

        // Stalled 0..7 read: outputs must hold the pending beat while out_ready is low.
        stall_pat = 16'b1011_0010_1101_0110;
        start(4'd0, 4'd7);
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 64) begin
            out_ready = stall_pat[cyc % 16];
            chk_beat(4'(k), exp_d[k], 1'b0, k == 7);
            tick();
            if (out_ready) k++;
            cyc++;
        end
        check("stall_done", k, 32'd8);
        out_ready = 1'b1;
        chk_idle("idle_after_stall");

        // Reset while the beat at idx3 is presented.
        start(4'd0, 4'd7);
        for (int i = 0; i < 3; i++) begin
            chk_beat(4'(i), exp_d[i], 1'b0, 1'b0);
            tick();
        end
        chk_beat(4'd3, exp_d[3], 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("after_reset");

        start(4'd5, 4'd5);
        chk_beat(4'd5, 8'h42, 1'b0, 1'b1);
        tick();
        chk_idle("idle_after_single");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
